mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single memory bus between the instruction-fetch port and the data port driven by the MMU (load/store). It grants one requester per bus transaction and registers the winning request onto the bus. It holds the bus until the memory acknowledges, then returns read data and a one-cycle acknowledge to the winner. Data accesses have priority, and a streak limit keeps fetch from starving; a timeout aborts hung transactions.

## Interface
- XLEN, 32, address/data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting (≥1)
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack (≥1)

- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr until if_ack
- if_addr  input  XLEN  fetch address
- if_ack  output  1  one-cycle completion pulse to fetch
- if_err  output  1  valid with if_ack; 1 = timed out
- if_rdata  output  XLEN  fetched word; valid with if_ack, held until next if_ack
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  input  1  1 = store, 0 = load
- d_addr  input  XLEN  data address
- d_wdata  input  XLEN  store data
- d_ack  output  1  one-cycle completion pulse to data port
- d_err  output  1  valid with d_ack; 1 = timed out
- d_rdata  output  XLEN  load data; valid with d_ack, held until next d_ack
- mem_req  output  1  bus request, held until mem_ack or timeout
- mem_we  output  1  bus write enable
- mem_addr  output  XLEN  bus address
- mem_wdata  output  XLEN  bus write data
- mem_ack  input  1  bus completion; mem_rdata valid same cycle
- mem_rdata  input  XLEN  bus read data

## Operation
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - A request counts only when its req is high and its own ack is low that cycle.
  - If only one counted request is present, grant it.
  - If both are present: grant data, unless streak == MAX_DATA_STREAK; in that case grant fetch.
  - On grant, register mem_addr/mem_we/mem_wdata from the winner and set mem_req=1.
  - Fetch grants drive mem_we=0 and mem_wdata=0. Data loads drive mem_wdata=0.
- BUSY_x:
  - mem_* outputs stay constant. Requester inputs are not resampled.
  - The timeout counter increments each cycle.
- mem_ack in BUSY_x:
  - Go to IDLE and drop mem_req.
  - Pulse x_ack=1 and x_err=0 next cycle.
  - Register x_rdata = mem_rdata. For stores, d_rdata is also loaded from mem_rdata.
- Timeout: if the counter reaches TIMEOUT with no mem_ack, go to IDLE, drop mem_req, and pulse x_ack=1, x_err=1. x_rdata keeps its old value.
- Streak counter:
  - A data grant while if_req is counted increments it, saturating at MAX_DATA_STREAK.
  - A fetch grant clears it.
  - A data grant with if_req low clears it.
- Reset sets the following on the next edge, and any in-flight transaction is dropped with no ack:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ack=if_err=d_ack=d_err=0
  - if_rdata=d_rdata=0
  - streak=0, timeout counter=0
- A mem_ack arriving in IDLE is ignored.

## Timing
- Grant latency: request counted in IDLE at cycle n → mem_req=1 at n+1.
- mem_ack at cycle m ≥ n+1 → x_ack=1 at m+1 and mem_req=0 at m+1.
- Back-to-back: the earliest next grant is decided in cycle m+1 (state IDLE); mem_req rises at m+2.
  - In cycle m+1 the acked port's req is ignored.
  - The other port's pending req is counted, so it wins at m+1.
- Minimum transaction: 3 cycles req-to-ack (mem_ack in the first mem_req cycle).
- Timeout: mem_req high for exactly TIMEOUT cycles; ack/err at the following cycle.
- x_ack never asserts for two consecutive cycles. if_ack and d_ack never assert in the same cycle.

## Test plan
- Single fetch: if_req, if_addr=0x100 at cycle 0 → mem_req=1, mem_addr=0x100, mem_we=0 at 1. Then mem_ack, mem_rdata=0xDEADBEEF at 1 → if_ack=1, if_err=0, if_rdata=0xDEADBEEF at 2; mem_req=0 at 2.
- Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0x12345678 → mem_we=1, mem_wdata=0x12345678. mem_ack after 3 wait cycles → d_ack exactly one cycle later.
- Simultaneous fetch and load, both held, mem_ack after 1 cycle each → data served first, fetch granted in the cycle d_ack is high, if_ack 3 cycles after d_ack.
- Starvation (MAX_DATA_STREAK=4): d_req re-asserted every idle cycle with if_req held high → exactly 4 data transactions, then fetch; streak then restarts.
- Timeout (TIMEOUT=8): load with mem_ack never asserted → mem_req high 8 cycles, then d_ack=1, d_err=1, d_rdata unchanged.
- Reset mid-transaction: rst during BUSY_IF → mem_req=0 next cycle; no if_ack; rdata regs 0. A mem_ack after reset produces no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for a single memory bus
//
// Purpose: grants one requester per bus transaction, registers the winning
// request onto the bus, holds it until mem_ack or timeout, then returns a
// one-cycle ack (with error flag) and read data to the winner. Data wins
// ties unless it has already won MAX_DATA_STREAK ties in a row.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and address
//   if_ack/if_err/if_rdata          fetch completion pulse, timeout flag, data
//   d_req/d_we/d_addr/d_wdata       data request, store flag, address, data
//   d_ack/d_err/d_rdata             data completion pulse, timeout flag, data
//   mem_req/mem_we/mem_addr/mem_wdata  registered bus request
//   mem_ack/mem_rdata               bus completion and read data

module mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic            if_err,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic            d_err,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;

  logic if_cnt;
  logic d_cnt;
  logic grant_d;
  logic grant_if;
  logic busy;
  logic tmo_hit;
  logic finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
        end else if (grant_if) begin
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode: grant decisions and transaction completion
  always_comb begin
    // A port whose ack is high this cycle has just been served; its req is
    // still the old one and must not start a second transaction.
    if_cnt   = if_req & ~if_ack;
    d_cnt    = d_req & ~d_ack;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    busy     = (state != IDLE);
    // A mem_ack in the last allowed cycle still counts as success.
    tmo_hit  = busy && !mem_ack && (tmo_cnt == TMO_LAST);
    finish   = busy && (mem_ack || tmo_hit);
    if (state == IDLE) begin
      grant_d  = d_cnt && !(if_cnt && (streak == STREAK_MAX));
      grant_if = if_cnt && !grant_d;
    end
  end

  // Bus request, completion and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      streak    <= '0;
      tmo_cnt   <= '0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_we ? d_wdata : '0;
        tmo_cnt   <= '0;
        // Only tie wins against a waiting fetch build the streak.
        if (if_cnt) begin
          streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
        end else begin
          streak <= '0;
        end
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        tmo_cnt   <= '0;
        streak    <= '0;
      end else if (finish) begin
        mem_req <= 1'b0;
        tmo_cnt <= '0;
        if (state == BUSY_IF) begin
          if_ack <= 1'b1;
          if_err <= ~mem_ack;
          if (mem_ack) begin
            if_rdata <= mem_rdata;
          end
        end else begin
          d_ack <= 1'b1;
          d_err <= ~mem_ack;
          if (mem_ack) begin
            d_rdata <= mem_rdata;
          end
        end
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule
